// File: rtl/seg_pkg.sv
// Shared segment encodings for the seven-segment scan driver.
// Segment order is {A,B,C,D,E,F,G}, A in the MSB, active-high.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Position of the decimal point in the 8-bit seg_led word.
  localparam int DP_BIT = 0;

endpackage

// File: rtl/seg_digit_decode.sv
// Combinational BCD to seven-segment decoder; values 10..15 decode to blank.
module seg_digit_decode
  import seg_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  always_comb begin
    case (value)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver with frame snapshot, leading-zero
// blanking and a one-clock anti-ghost gap. Blinking is built only with SEG_SCAN_BLINK_EN.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   num_bus,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic                  blank_en,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic [7:0]            seg_led,
  output logic [DIGITS-1:0]     dig_sel
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]    cnt_p0;
  logic [IDX_W-1:0]    idx_p0;
  logic                vld_p0;
  logic [4*DIGITS-1:0] num_snap;
  logic [DIGITS-1:0]   dp_snap;
  logic                blank_snap;
  logic                slot_edge;
  logic                frame_wrap;

  assign slot_edge  = (cnt_p0 == CNT_LAST);
  assign frame_wrap = slot_edge && (idx_p0 == IDX_LAST);

  // Stage 0: prescaler, digit index and frame snapshot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p0     <= '0;
      idx_p0     <= IDX_LAST;
      vld_p0     <= 1'b0;
      num_snap   <= '0;
      dp_snap    <= '0;
      blank_snap <= 1'b0;
    end else begin
      vld_p0 <= slot_edge;
      if (slot_edge) begin
        cnt_p0 <= '0;
        idx_p0 <= (idx_p0 == IDX_LAST) ? '0 : idx_p0 + IDX_W'(1);
      end else begin
        cnt_p0 <= cnt_p0 + CNT_W'(1);
      end
      if (frame_wrap) begin
        num_snap   <= num_bus;
        dp_snap    <= dp_mask;
        blank_snap <= blank_en;
      end
    end
  end

`ifdef SEG_SCAN_BLINK_EN
  localparam int FR_W = $clog2(BLINK_DIV + 1);

  logic [FR_W-1:0]   frame_cnt;
  logic              phase_on;
  logic [DIGITS-1:0] blink_snap;
  logic              blink_bit;

  // Counter runs 1..BLINK_DIV after the first wrap, so the first half-period
  // covers frames 0..BLINK_DIV-1 exactly like every later one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt  <= '0;
      phase_on   <= 1'b1;
      blink_snap <= '0;
    end else if (frame_wrap) begin
      blink_snap <= blink_mask;
      if (frame_cnt == FR_W'(BLINK_DIV)) begin
        frame_cnt <= FR_W'(1);
        phase_on  <= ~phase_on;
      end else begin
        frame_cnt <= frame_cnt + FR_W'(1);
      end
    end
  end

  always_comb begin
    blink_bit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_p0 == IDX_W'(i)) blink_bit = blink_snap[i];
    end
  end
`else
  localparam int unused_blink_div = BLINK_DIV;
  logic unused_blink;
  assign unused_blink = ^blink_mask;
`endif

  logic [3:0]        digit_val;
  logic              dp_bit;
  logic              blank_digit;
  logic              zero_above;
  logic [DIGITS-1:0] dig_next;
  logic [6:0]        seg_dec;
  logic [7:0]        seg_next;

  // Scan from the most significant digit so zero_above holds "this digit and
  // every digit above it are zero" when the selected index is reached.
  always_comb begin
    digit_val   = '0;
    dp_bit      = 1'b0;
    blank_digit = 1'b0;
    zero_above  = 1'b1;
    dig_next    = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (num_snap[4*i +: 4] == 4'd0);
      if (idx_p0 == IDX_W'(i)) begin
        dig_next[i] = 1'b1;
        digit_val   = num_snap[4*i +: 4];
        dp_bit      = dp_snap[i];
        blank_digit = blank_snap && (i != 0) && zero_above;
      end
    end
  end

  seg_digit_decode u_decode (
    .value (digit_val),
    .seg   (seg_dec)
  );

  always_comb begin
    seg_next         = {(blank_digit ? SEG_BLANK : seg_dec), 1'b0};
    seg_next[DP_BIT] = dp_bit;
`ifdef SEG_SCAN_BLINK_EN
    if (!phase_on && blink_bit) seg_next = '0;
`endif
  end

  // Stage 1: registered outputs, dark for one clock at each slot edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_sel <= '0;
      seg_led <= '0;
    end else if (slot_edge) begin
      dig_sel <= '0;
      seg_led <= '0;
    end else if (vld_p0) begin
      dig_sel <= dig_next;
      seg_led <= seg_next;
    end
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of multiplexed digits, legal range 1..8.
REQ-002 SHALL have parameter SCAN_DIV, default 50000: clocks per digit slot, legal range >=2.
REQ-003 SHALL have parameter BLINK_DIV, default 64: scan frames per blink half-period, legal range >=1.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port num_bus  input  4*DIGITS  digit values; digit i = num_bus[4i+3:4i], digit 0 least significant.
REQ-007 SHALL have port dp_mask  input  DIGITS  decimal-point enable per digit.
REQ-008 SHALL have port blank_en  input  1  leading-zero blanking enable.
REQ-009 SHALL have port blink_mask  input  DIGITS  blink enable per digit, present in both builds.
REQ-010 SHALL have port seg_led  output  8  segments {A,B,C,D,E,F,G,DP}, A = bit 7, active-high.
REQ-011 SHALL have port dig_sel  output  DIGITS  one-hot digit enable, active-high.

Function
REQ-012 SHALL run prescaler cnt 0..SCAN_DIV-1, wrapping; a slot edge is any edge where cnt==SCAN_DIV-1.
REQ-013 SHALL advance digit index idx on each slot edge, DIGITS-1 wraps to 0.
REQ-014 SHALL, on the slot edge where idx wraps to 0, snapshot num_bus, dp_mask, blank_en and blink_mask; input changes at other times SHALL NOT be displayed until the next snapshot.
REQ-015 SHALL drive dig_sel=0 and seg_led=0 on each slot edge (one-clock anti-ghost gap).
REQ-016 SHALL, on the edge after a slot edge, set dig_sel=onehot(idx) and seg_led=decode(snapshot digit idx); both outputs are registered and held until the next slot edge.
REQ-017 SHALL decode 0..9 as: 0=11111100, 1=01100000, 2=11011010, 3=11110010, 4=01100110, 5=10110110, 6=10111110, 7=11100000, 8=11111110, 9=11110110.
REQ-018 SHALL decode values 10..15 to seg_led[7:1]=0 (blank); DP still per dp_mask.
REQ-019 SHALL OR dp_mask[idx] into seg_led[0].
REQ-020 SHALL, when snapshot blank_en=1, blank digit i>0 (seg_led[7:1]=0) if digit i and all more-significant digits are 0; digit 0 is never blanked; DP is unaffected.
REQ-021 SHALL, when DIGITS==1, degenerate to a static driver: idx fixed at 0, snapshot on every slot edge.

Reset
REQ-022 SHALL, while rst_n=0, force cnt=0, idx=DIGITS-1, dig_sel=0, seg_led=0, snapshot=0, blink frame counter=0, blink phase=on, independent of clk.
REQ-023 SHALL, after rst_n deasserts, wrap idx to 0 on the first slot edge (snapshot taken), with dig_sel=1 on the following edge, i.e. SCAN_DIV+1 edges after release.
REQ-024 SHALL, on reset asserted mid-slot, clear outputs immediately with no partial-frame completion.

Configuration
REQ-025 SHALL implement blinking only when SEG_SCAN_BLINK_EN is defined: the frame counter counts idx wraps; the phase toggles every BLINK_DIV frames; in the off phase, digits with snapshot blink_mask set output seg_led=0 while dig_sel is still driven.
REQ-026 SHALL, when SEG_SCAN_BLINK_EN is undefined, ignore blink_mask and omit the frame counter and phase logic; all other behaviour is identical.

Structure
REQ-027 SHALL place segment constants SEG_0..SEG_9 and SEG_BLANK, plus a DP bit index constant, in shared package seg_pkg.
REQ-028 SHALL instantiate one combinational sub-module seg_digit_decode (4-bit value in, 7 segments out, 10..15 blank).

Verification (DIGITS=4, SCAN_DIV=4, BLINK_DIV=2)
REQ-029 SHALL cover basic scan: num_bus=16'h1234, dp_mask=0, blank_en=0 -> slots digit0 0001/01100110, digit1 0010/11110010, digit2 0100/11011010, digit3 1000/01100000, each followed by a one-clock 0/0 gap.
REQ-030 SHALL cover leading-zero blanking: blank_en=1, num_bus=16'h0070 -> digits 3,2 seg 00000000; digit1 11100000; digit0 11111100. num_bus=0 -> only digit0 11111100.
REQ-031 SHALL cover out-of-range value and DP: digit0=4'hA -> 00000000; digit0=5 with dp_mask=0001 -> 10110111.
REQ-032 SHALL cover snapshot coherence: num_bus 16'h1234 -> 16'h5678 while idx=1 -> digits 2,3 still show 2,1; the next frame shows 8,7,6,5.
REQ-033 SHALL cover asynchronous reset: rst_n low mid-slot with dig_sel=0100 -> dig_sel=0 and seg_led=0 before the next clk edge; first dig_sel=0001 occurs 5 edges after release.
REQ-034 SHALL cover blinking: with the macro and blink_mask=0010, digit1 shows segments in frames 0-1, 00000000 in frames 2-3, then segments again; without the macro, digit1 is always lit.
